// File: rtl/pc_seq.sv
// pc_seq: parametrised MIPS fetch program-counter sequencer with delay slot, exception vector and halt
// Ports: clk, reset (async, active-high); en/stall gate advancing; redirect_valid/redirect_target
// request a branch; exc loads EXC_VECTOR; halt_req stops fetching until reset.
// Outputs: addr (fetch address), delay_slot (addr is a delay-slot fetch), halted, align_err (1-cycle pulse).
module pc_seq #(
    parameter int W = 32,
    parameter logic [W-1:0] RESET_VECTOR = W'(32'hBFC00000),
    parameter logic [W-1:0] EXC_VECTOR = W'(32'hBFC00380),
    parameter int INCR = 4,
    parameter bit DELAY_SLOT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [W-1:0] redirect_target,
    input  logic         exc,
    input  logic         halt_req,
    output logic [W-1:0] addr,
    output logic         delay_slot,
    output logic         halted,
    output logic         align_err
);
    typedef enum logic [1:0] {RUN, DELAY, HALT} state_t;
    localparam logic [W-1:0] STEP = W'(INCR);
    state_t state, state_n;
    logic [W-1:0] pending, pending_n, addr_n;
    logic align_n, adv;
    assign adv = en & ~stall & (state != HALT);
    assign delay_slot = state == DELAY;
    assign halted = state == HALT;
    always_comb begin
        state_n = state;
        addr_n = addr;
        pending_n = pending;
        align_n = 1'b0;
        if (state == HALT) begin
            state_n = HALT;
        end else if (exc) begin
            addr_n = EXC_VECTOR;
            pending_n = '0;
            state_n = RUN;
        end else if (!adv) begin
            state_n = state;
        end else if (halt_req) begin
            pending_n = '0;
            state_n = HALT;
        end else if (state == DELAY) begin
            addr_n = pending;
            state_n = RUN;
        end else if (redirect_valid && redirect_target[1:0] != 2'b00) begin
            addr_n = EXC_VECTOR;
            align_n = 1'b1;
            state_n = RUN;
        end else if (redirect_valid) begin
            addr_n = DELAY_SLOT ? addr + STEP : redirect_target;
            pending_n = DELAY_SLOT ? redirect_target : pending;
            state_n = DELAY_SLOT ? DELAY : RUN;
        end else begin
            addr_n = addr + STEP;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            addr <= RESET_VECTOR;
            pending <= '0;
            align_err <= 1'b0;
        end else begin
            state <= state_n;
            addr <= addr_n;
            pending <= pending_n;
            align_err <= align_n;
        end
    end
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed table-driven bench for pc_seq (32-bit delay-slot and 8-bit immediate instances)
module tb_pc_seq;
    logic clk = 1'b0;
    logic reset = 1'b1, en = 1'b0, stall = 1'b0, rv = 1'b0, exc = 1'b0, hr = 1'b0;
    logic [31:0] tgt = '0, addr;
    logic ds, halted, ae;
    logic rst8 = 1'b1, en8 = 1'b0, rv8 = 1'b0;
    logic [7:0] tgt8 = '0, addr8;
    logic ds8, halted8, ae8;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    pc_seq dut (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .redirect_valid(rv),
        .redirect_target(tgt), .exc(exc), .halt_req(hr), .addr(addr),
        .delay_slot(ds), .halted(halted), .align_err(ae)
    );

    pc_seq #(.W(8), .RESET_VECTOR(8'hF8), .EXC_VECTOR(8'h80), .INCR(4), .DELAY_SLOT(1'b0)) dut8 (
        .clk(clk), .reset(rst8), .en(en8), .stall(1'b0), .redirect_valid(rv8),
        .redirect_target(tgt8), .exc(1'b0), .halt_req(1'b0), .addr(addr8),
        .delay_slot(ds8), .halted(halted8), .align_err(ae8)
    );

    typedef struct {
        logic en, stall, rv;
        logic [31:0] tgt;
        logic exc, hr;
        logic [31:0] a;
        logic ds, h, ae;
    } vec_t;
    vec_t v[$];

    function automatic vec_t mk(logic e, logic s, logic r, logic [31:0] t, logic x, logic q,
                                logic [31:0] a, logic d, logic h, logic ae_e);
        vec_t r_v;
        r_v.en = e; r_v.stall = s; r_v.rv = r; r_v.tgt = t; r_v.exc = x; r_v.hr = q;
        r_v.a = a; r_v.ds = d; r_v.h = h; r_v.ae = ae_e;
        return r_v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string name, logic [31:0] a, logic d, logic h, logic ae_e);
        chk({name, ".addr"}, addr, a);
        chk({name, ".delay_slot"}, {31'b0, ds}, {31'b0, d});
        chk({name, ".halted"}, {31'b0, halted}, {31'b0, h});
        chk({name, ".align_err"}, {31'b0, ae}, {31'b0, ae_e});
    endtask

    task automatic step(logic e, logic s, logic r, logic [31:0] t, logic x, logic q);
        en = e; stall = s; rv = r; tgt = t; exc = x; hr = q;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        en = 0; stall = 0; rv = 0; tgt = 0; exc = 0; hr = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic step8(logic e, logic r, logic [7:0] t, logic [7:0] a, logic ae_e, string name);
        en8 = e; rv8 = r; tgt8 = t;
        @(posedge clk);
        #1;
        chk({name, ".addr8"}, {24'b0, addr8}, {24'b0, a});
        chk({name, ".align8"}, {31'b0, ae8}, {31'b0, ae_e});
        chk({name, ".ds8"}, {30'b0, halted8, ds8}, 32'd0);
    endtask

    initial begin
        v.push_back(mk(1,0,0,0,0,0, 32'hBFC00004,0,0,0));
        v.push_back(mk(1,0,0,0,0,0, 32'hBFC00008,0,0,0));
        v.push_back(mk(1,0,0,0,0,0, 32'hBFC0000C,0,0,0));
        v.push_back(mk(1,0,0,0,0,0, 32'hBFC00010,0,0,0));
        v.push_back(mk(1,0,1,32'h00400000,0,0, 32'hBFC00014,1,0,0));
        v.push_back(mk(1,0,1,32'h00500000,0,0, 32'h00400000,0,0,0));
        v.push_back(mk(1,0,0,0,0,0, 32'h00400004,0,0,0));
        v.push_back(mk(1,0,1,32'h00600000,0,0, 32'h00400008,1,0,0));
        v.push_back(mk(1,1,0,0,0,0, 32'h00400008,1,0,0));
        v.push_back(mk(1,1,1,32'h00900000,0,0, 32'h00400008,1,0,0));
        v.push_back(mk(1,1,0,0,0,0, 32'h00400008,1,0,0));
        v.push_back(mk(0,0,0,0,0,0, 32'h00400008,1,0,0));
        v.push_back(mk(1,0,0,0,0,0, 32'h00600000,0,0,0));
        v.push_back(mk(1,0,1,32'h00400002,0,0, 32'hBFC00380,0,0,1));
        v.push_back(mk(1,0,0,0,0,0, 32'hBFC00384,0,0,0));
        v.push_back(mk(1,1,0,0,1,0, 32'hBFC00380,0,0,0));
        v.push_back(mk(0,0,0,0,1,0, 32'hBFC00380,0,0,0));
        v.push_back(mk(1,0,0,0,0,0, 32'hBFC00384,0,0,0));
        v.push_back(mk(1,0,1,32'h00700000,0,0, 32'hBFC00388,1,0,0));
        v.push_back(mk(1,0,0,0,1,0, 32'hBFC00380,0,0,0));
        v.push_back(mk(1,0,0,0,0,0, 32'hBFC00384,0,0,0));
        v.push_back(mk(1,1,0,0,0,1, 32'hBFC00384,0,0,0));
        v.push_back(mk(1,0,1,32'h00800000,0,0, 32'hBFC00388,1,0,0));
        v.push_back(mk(1,0,1,32'h00A00000,0,1, 32'hBFC00388,0,1,0));
        v.push_back(mk(1,0,1,32'h00B00000,1,0, 32'hBFC00388,0,1,0));
        v.push_back(mk(1,0,1,32'h00000012,0,0, 32'hBFC00388,0,1,0));
        v.push_back(mk(1,0,0,0,0,0, 32'hBFC00388,0,1,0));

        do_reset();
        chk_all("reset", 32'hBFC00000, 0, 0, 0);
        foreach (v[i]) begin
            step(v[i].en, v[i].stall, v[i].rv, v[i].tgt, v[i].exc, v[i].hr);
            chk_all($sformatf("vec%0d", i), v[i].a, v[i].ds, v[i].h, v[i].ae);
        end

        // halt at BFC00008, frozen against exc/redirect, then async reset mid-halt
        do_reset();
        step(1,0,0,0,0,0);
        step(1,0,0,0,0,0);
        chk_all("pre_halt", 32'hBFC00008, 0, 0, 0);
        step(1,0,0,0,0,1);
        chk_all("halt", 32'hBFC00008, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, i[0], 1, 32'(i * 4 + 1), (i % 3) == 0, i[1]);
            chk_all($sformatf("frozen%0d", i), 32'hBFC00008, 0, 1, 0);
        end
        #2 reset = 1;
        #1 chk_all("halt_async_reset", 32'hBFC00000, 0, 0, 0);
        @(posedge clk);
        #1 reset = 0;
        step(1,0,0,0,0,0);
        chk_all("after_halt_reset", 32'hBFC00004, 0, 0, 0);

        // async reset between edges while in DELAY discards the pending target
        step(1,0,1,32'h00400000,0,0);
        chk_all("delay_pre_reset", 32'hBFC00008, 1, 0, 0);
        #2 reset = 1;
        #1 chk_all("delay_async_reset", 32'hBFC00000, 0, 0, 0);
        @(posedge clk);
        #1 reset = 0;
        step(1,0,0,0,0,0);
        chk_all("no_stale_target", 32'hBFC00004, 0, 0, 0);
        step(1,0,0,0,0,0);
        chk_all("no_stale_target2", 32'hBFC00008, 0, 0, 0);

        // 8-bit instance, immediate redirects and modulo wrap
        @(posedge clk);
        #1 rst8 = 0;
        chk({"w8_reset", ".addr8"}, {24'b0, addr8}, 32'h000000F8);
        step8(1, 0, 8'h00, 8'hFC, 0, "w8_a");
        step8(1, 0, 8'h00, 8'h00, 0, "w8_wrap");
        step8(1, 0, 8'h00, 8'h04, 0, "w8_b");
        step8(1, 1, 8'h40, 8'h40, 0, "w8_redirect");
        step8(1, 0, 8'h00, 8'h44, 0, "w8_c");
        step8(0, 0, 8'h00, 8'h44, 0, "w8_hold");
        step8(1, 1, 8'h41, 8'h80, 1, "w8_misalign");
        step8(1, 0, 8'h00, 8'h84, 0, "w8_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
